// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the shared-multiplier controller.
package mul_ctrl_pkg;

    localparam int DEFAULT_W = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_MULT   = 3'd3;
    localparam logic [2:0] ST_FIN    = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD_A = ST_LOAD_A,
        LOAD_B = ST_LOAD_B,
        MULT   = ST_MULT,
        FIN    = ST_FIN
    } state_t;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Requester/datapath bundle seen by the shared-multiplier controller.
interface mul_share_ctrl_if
    import mul_ctrl_pkg::*;
#(
    parameter int W = DEFAULT_W
);
    logic [1:0]   req;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         eqz;
    logic [W-1:0] dp_bus;
    logic         lda;
    logic         ldb;
    logic         clrp;
    logic         ldp;
    logic         decb;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         busy;

    modport master (
        input  req, a0, b0, a1, b1, eqz,
        output dp_bus, lda, ldb, clrp, ldp, decb, gnt, done, busy
    );

    modport slave (
        output req, a0, b0, a1, b1, eqz,
        input  dp_bus, lda, ldb, clrp, ldp, decb, gnt, done, busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_req == 2'b11) begin
            o_gnt = i_last ? 2'b01 : 2'b10;
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Controller sharing one repeated-addition multiplier datapath between two requesters.
module mul_share_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    mul_share_ctrl_if.master  bus
);

    state_t       r_state;
    logic [1:0]   r_gnt;
    logic         r_last;

    logic [1:0]   w_arb_gnt;
    logic         w_owner;
    logic [W-1:0] w_opa;
    logic [W-1:0] w_opb;

    rr_arb2 u_arb (
        .i_req  (bus.req),
        .i_last (r_last),
        .o_gnt  (w_arb_gnt)
    );

    assign w_owner = r_gnt[1];
    assign w_opa   = w_owner ? bus.a1 : bus.a0;
    assign w_opb   = w_owner ? bus.b1 : bus.b0;

    // Once granted, the job runs to FIN regardless of req; only reset abandons it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_state <= LOAD_A;
                        r_gnt   <= w_arb_gnt;
                    end
                end
                LOAD_A:  r_state <= LOAD_B;
                LOAD_B:  r_state <= MULT;
                MULT: begin
                    if (bus.eqz) r_state <= FIN;
                end
                FIN: begin
                    r_last  <= r_gnt[1];
                    r_gnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.dp_bus = '0;
        bus.lda    = 1'b0;
        bus.ldb    = 1'b0;
        bus.clrp   = 1'b0;
        bus.ldp    = 1'b0;
        bus.decb   = 1'b0;
        bus.done   = '0;
        bus.gnt    = r_gnt;
        bus.busy   = (r_state != IDLE);
        case (r_state)
            LOAD_A: begin
                bus.dp_bus = w_opa;
                bus.lda    = 1'b1;
            end
            LOAD_B: begin
                bus.dp_bus = w_opb;
                bus.ldb    = 1'b1;
                bus.clrp   = 1'b1;
            end
            MULT: begin
                bus.ldp  = ~bus.eqz;
                bus.decb = ~bus.eqz;
            end
            FIN:     bus.done = r_gnt;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl with a behavioural repeated-addition datapath.
module tb_mul_share_ctrl;

    localparam int W = 16;

    typedef struct {
        logic [1:0]     own;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        bit             btb;
    } job_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mul_share_ctrl_if #(.W(W)) bus ();

    mul_share_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    job_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural datapath: A, B, P registers driven by the strobes.
    logic [W-1:0]   m_a = '0;
    logic [W-1:0]   m_b = '0;
    logic [2*W-1:0] m_p = '0;
    assign bus.eqz = (m_b == '0);

    always @(posedge clk) begin
        if (bus.lda) m_a <= bus.dp_bus;
        if (bus.ldb) m_b <= bus.dp_bus;
        else if (bus.decb) m_b <= m_b - 1'b1;
        if (bus.clrp) m_p <= '0;
        else if (bus.ldp) m_p <= m_p + {{W{1'b0}}, m_a};
    end

    // Requesters: the sole driver of req; clears a bit on the edge done is seen.
    int issued [2] = '{0, 0};
    int served [2] = '{0, 0};
    bit drop   [2] = '{0, 0};

    initial begin
        logic [1:0] d;
        bus.req = '0;
        forever begin
            @(negedge clk);
            d = bus.done;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (d[i]) served[i]++;
                bus.req[i] = (issued[i] != served[i]) && !drop[i];
            end
        end
    end

    // Monitor: pops the expected job whenever the DUT presents a strobe of interest.
    int  cyc = 0;
    int  lda_cyc = 0;
    int  last_done = -100;
    int  nldp = 0;
    bit  active = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
            nldp   = 0;
        end else begin
            if (bus.lda) begin
                chk("lda_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    chk("lda_dp_bus", bus.dp_bus, q[0].a);
                    chk("lda_gnt", bus.gnt, q[0].own);
                    if (q[0].btb) chk("one_idle_gap", cyc - last_done, 2);
                end
                active  = 1;
                lda_cyc = cyc;
                nldp    = 0;
            end
            if (bus.ldb && q.size() != 0) begin
                chk("ldb_dp_bus", bus.dp_bus, q[0].b);
                chk("ldb_clrp", bus.clrp, 1);
            end
            if (bus.ldp) nldp++;
            if (bus.done != 2'b00) begin
                chk("done_expected", (q.size() != 0) && active, 1);
                if (q.size() != 0) begin
                    chk("done_owner", bus.done, q[0].own);
                    chk("product", m_p, q[0].p);
                    chk("ldp_count", nldp, q[0].b);
                    chk("latency", cyc - lda_cyc, 3 + q[0].b);
                    void'(q.pop_front());
                end
                last_done = cyc;
                active    = 0;
            end
            cyc++;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_gnt"}, bus.gnt, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_strobes"}, {bus.lda, bus.ldb, bus.clrp, bus.ldp, bus.decb}, 0);
        chk({tag, "_dp_bus"}, bus.dp_bus, 0);
    endtask

    task automatic push(input logic [1:0] own, input int a, input int b, input bit btb);
        job_t j;
        j.own = own;
        j.a   = W'(a);
        j.b   = W'(b);
        j.p   = (2*W)'(a) * (2*W)'(b);
        j.btb = btb;
        q.push_back(j);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.busy && bus.req == 2'b00) begin
                ok = 1;
                break;
            end
        end
        chk({nm, "_completes"}, ok, 1);
    endtask

    initial begin
        bit seen;
        int nl;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;

        // Reset held with both requesters pending; contention jobs queued in grant order.
        bus.a0 = 16'd2; bus.b0 = 16'd2;
        bus.a1 = 16'd3; bus.b1 = 16'd1;
        push(2'b01, 2, 2, 0);
        push(2'b10, 3, 1, 1);
        issued[0] = 1; issued[1] = 1;
        #1;
        check_zero("rst_t0");
        repeat (3) @(negedge clk);
        chk("rst_req_held", bus.req, 2'b11);
        check_zero("rst_held");
        rst_n = 1'b1;

        // Requester 0 re-requests right after its first done: grants 01, 10, 01.
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (served[0] == 1) begin seen = 1; break; end
        end
        chk("first_job_served", seen, 1);
        bus.a0 = 16'd6; bus.b0 = 16'd2;
        push(2'b01, 6, 2, 1);
        issued[0]++;
        wait_idle("contention", 60);

        bus.a0 = 16'd5; bus.b0 = 16'd3;
        push(2'b01, 5, 3, 0);
        issued[0]++;
        wait_idle("single", 40);

        // Requester 0 served last, simultaneous requests: requester 1 must win.
        bus.a0 = 16'd1; bus.b0 = 16'd1;
        bus.a1 = 16'd7; bus.b1 = 16'd2;
        push(2'b10, 7, 2, 0);
        push(2'b01, 1, 1, 1);
        issued[0]++; issued[1]++;
        wait_idle("rr_swap", 60);

        bus.a1 = 16'd9; bus.b1 = 16'd0;
        push(2'b10, 9, 0, 0);
        issued[1]++;
        wait_idle("zero_mult", 40);

        bus.a0 = 16'hFFFF; bus.b0 = 16'd2;
        push(2'b01, 32'hFFFF, 2, 0);
        issued[0]++;
        wait_idle("max_a", 40);

        // Requester 0 withdraws req mid-MULT; the job must still finish once.
        bus.a0 = 16'd4; bus.b0 = 16'd5;
        push(2'b01, 4, 5, 0);
        issued[0]++;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.ldp) begin seen = 1; break; end
        end
        chk("drop_reached_mult", seen, 1);
        drop[0] = 1;
        wait_idle("req_drop", 40);
        drop[0] = 0;
        repeat (4) @(negedge clk);
        chk("drop_no_restart", bus.busy, 0);

        // Reset pulsed in the second ldp cycle; held req restarts the job.
        bus.a1 = 16'd3; bus.b1 = 16'd4;
        push(2'b10, 3, 4, 0);
        issued[1]++;
        nl = 0;
        for (int k = 0; k < 20 && nl < 2; k++) begin
            @(negedge clk);
            if (bus.ldp) nl++;
        end
        chk("mid_mult_reached", nl, 2);
        #1 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        @(negedge clk);
        check_zero("rst_mid_hold");
        rst_n = 1'b1;
        wait_idle("rst_restart", 60);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mul_share_ctrl.md
MUL_SHARE_CTRL -- requirements
Module: mul_share_ctrl

Interface
REQ-001 SHALL have parameter W, default 16, giving the operand and datapath-bus width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  2  per-requester job request; held high until that requester's done pulse.
REQ-005 SHALL have ports a0, b0, a1, b1  input  W each  multiplicand and multiplier operands of requesters 0 and 1; stable while req is high.
REQ-006 SHALL have port eqz  input  1  datapath flag, high when the datapath B register equals 0.
REQ-007 SHALL have port dp_bus  output  W  operand driven to the shared repeated-addition datapath.
REQ-008 SHALL have ports lda, ldb, clrp, ldp, decb  output  1 each  datapath strobes: load A, load B, clear P, load P (P+A), decrement B.
REQ-009 SHALL have port gnt  output  2  one-hot owner of the datapath; 0 when idle.
REQ-010 SHALL have port done  output  2  one-cycle pulse to the owning requester; product P is valid in the datapath that cycle and holds until the next clrp.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, MULT and FIN.
REQ-013 IDLE: SHALL go to LOAD_A when any req bit is high, latching the winner into the grant register; otherwise SHALL stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins; after reset requester 0 has priority.
REQ-015 LOAD_A: dp_bus = a[owner], lda = 1; next state LOAD_B.
REQ-016 LOAD_B: dp_bus = b[owner], ldb = 1, clrp = 1; next state MULT.
REQ-017 MULT: while eqz = 0, ldp = 1 and decb = 1 and the FSM stays in MULT; when eqz = 1, ldp = decb = 0 and next state is FIN.
REQ-018 FIN: done[owner] = 1 for exactly one cycle; last-served pointer updated to owner; gnt cleared on exit; next state IDLE.
REQ-019 Strobes, dp_bus, gnt, done and busy SHALL be decoded from the registered state, grant register and eqz only, with no inserted delays and no latches; all are 0 in states where they are not specified.
REQ-020 Latency: with req sampled in IDLE at cycle t and multiplier value B, done SHALL be asserted at cycle t+4+B; B = 0 gives zero ldp pulses and P = 0.
REQ-021 Each requester SHALL clear req on the edge at which it samples done high, so back-to-back jobs incur exactly one IDLE cycle.
REQ-022 req dropping mid-job (protocol violation) SHALL NOT abort the job; the job completes and done still pulses.
REQ-023 Operand width rules: the product width is the datapath's concern; this block does not count or compare B itself and relies solely on eqz.

Reset
REQ-024 rst_n low SHALL asynchronously force state = IDLE, grant register = 0, last-served pointer = requester 1 (so requester 0 wins first), and all outputs = 0.
REQ-025 Reset asserted mid-job SHALL abandon the job with no done pulse; a request still pending after reset release SHALL restart from LOAD_A.

Structure
REQ-026 Shared package mul_ctrl_pkg SHALL hold the state enum typedef and the default width constant.
REQ-027 The round-robin arbiter SHALL be a sub-module rr_arb2 (2-bit req, last pointer in, one-hot grant out); the FSM and decode stay in mul_share_ctrl.

Verification
REQ-028 Reset: rst_n low with req = 2'b11 -> all outputs 0 immediately; busy stays 0 until rst_n is released.
REQ-029 Single job: req = 01, a0 = 5, b0 = 3 -> lda with dp_bus = 5, then ldb+clrp with dp_bus = 3, three ldp/decb cycles, done = 01 at t+7, bench datapath model P = 15.
REQ-030 Zero multiplier: req = 10, a1 = 9, b1 = 0 -> no ldp pulses, done = 10 at t+4, P = 0.
REQ-031 Contention: req = 11 held, operands 2x2 and 3x1 -> grants alternate 01, 10, 01 with one IDLE cycle between jobs; P values 4 and 3.
REQ-032 Reset mid-MULT: rst_n pulsed low during the second ldp cycle -> outputs 0 at once, no done; after release the same held req completes with the correct P.
REQ-033 Request drop: req[0] deasserted during MULT -> job finishes and done = 01 pulses once.
